// File: rtl/bcd_seq_if.sv
// Handshake and operand bundle for the digit-serial BCD adder.
interface bcd_seq_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   s;
    logic                  cout;
    logic                  err;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, err
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, err
    );
endinterface

// File: rtl/bcd_seq_adder.sv
// Digit-serial packed-BCD adder: one digit per clock through a single add/correct slice.
// Optional subtract mode (nine's complement of b, initial carry 1) is enabled by BCD_SUB_EN.
module bcd_seq_adder #(
    parameter int unsigned DIGITS = 4
) (
    input logic     clk,
    input logic     rst_n,
    bcd_seq_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [W-1:0]    b_cap;
    logic            carry_cap;
    logic            err_cap;

    // Operand B as stored: nine's complement per digit when subtracting.
`ifdef BCD_SUB_EN
    always_comb begin
        b_cap = bus.b;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.sub) b_cap[4*i +: 4] = 4'd9 - bus.b[4*i +: 4];
        end
        carry_cap = bus.sub ? 1'b1 : bus.cin;
    end
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign b_cap      = bus.b;
    assign carry_cap  = bus.cin;
`endif

    always_comb begin
        err_cap = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            err_cap = err_cap | (bus.a[4*i +: 4] > 4'd9) | (bus.b[4*i +: 4] > 4'd9);
        end
    end

    // Single-digit add/correct slice at the current index.
    logic [W-1:0] shamt;
    logic [3:0]   a_dig, b_dig, digit;
    logic [4:0]   t;
    logic         gt9;

    always_comb begin
        shamt = W'({idx_q, 2'b00});
        a_dig = 4'(a_q >> shamt);
        b_dig = 4'(b_q >> shamt);
        t     = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
        gt9   = (t > 5'd9);
        digit = gt9 ? 4'(t[3:0] + 4'd6) : t[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;

        case (state_q)
            StRun: begin
                s_d     = (s_q & ~(W'(4'hF) << shamt)) | (W'(digit) << shamt);
                carry_d = gt9;
                if (idx_q == LastIdx) begin
                    cout_d  = gt9;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone:  state_d = StIdle;
            StIdle:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if ((state_q == StIdle || state_q == StDone) && bus.start) begin
            state_d = StRun;
            a_d     = bus.a;
            b_d     = b_cap;
            s_d     = '0;
            idx_d   = '0;
            carry_d = carry_cap;
            cout_d  = 1'b0;
            err_d   = err_cap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_seq_adder.sv
// Directed-vector bench for bcd_seq_adder with DIGITS=4; subtract vectors need BCD_SUB_EN.
module tb_bcd_seq_adder;
    localparam int unsigned DIGITS = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   lat;

    bcd_seq_if #(.DIGITS(DIGITS)) bus ();

    bcd_seq_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive operands with start, let the next edge accept them, then drop start.
    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cinv,
                          input logic subv);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = cinv;
        bus.sub   = subv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_result(input string tag, input logic [15:0] es, input logic ec,
                                 input logic ee);
        check_eq({tag, "_s"}, 32'(bus.s), 32'(es));
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check_eq({tag, "_err"}, 32'(bus.err), 32'(ee));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #3;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        expect_result("rst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_done("add1", DIGITS);
        expect_result("add1", 16'h6912, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done_pulse_one_cycle", 32'(bus.done), 32'd0);
        expect_result("add1_hold", 16'h6912, 1'b0, 1'b0);

        launch(16'h9999, 16'h0001, 1'b0, 1'b0);
        wait_done("ripple", DIGITS);
        expect_result("ripple", 16'h0000, 1'b1, 1'b0);

        launch(16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_done("cin", DIGITS);
        expect_result("cin", 16'h0001, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
        launch(16'h0500, 16'h0123, 1'b0, 1'b1);
        wait_done("sub_pos", DIGITS);
        expect_result("sub_pos", 16'h0377, 1'b1, 1'b0);

        launch(16'h0123, 16'h0500, 1'b0, 1'b1);
        wait_done("sub_neg", DIGITS);
        expect_result("sub_neg", 16'h9623, 1'b0, 1'b0);
`else
        launch(16'h0500, 16'h0123, 1'b0, 1'b1);
        wait_done("sub_ignored", DIGITS);
        expect_result("sub_ignored", 16'h0623, 1'b0, 1'b0);
`endif

        launch(16'h00A0, 16'h0001, 1'b0, 1'b0);
        wait_done("invalid", DIGITS);
        expect_result("invalid", 16'h0101, 1'b0, 1'b1);

        // Restart attempt mid-RUN with different operands and inputs changed.
        launch(16'h1234, 16'h5678, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.a     = 16'h9999;
        bus.b     = 16'h0001;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("restart_ignored", DIGITS - 2);
        expect_result("restart_ignored", 16'h6912, 1'b0, 1'b0);

        // Back-to-back: start high during the DONE cycle.
        bus.a     = 16'h0045;
        bus.b     = 16'h0055;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check_eq("b2b_busy", 32'(bus.busy), 32'd1);
        check_eq("b2b_no_done", 32'(bus.done), 32'd0);
        wait_done("b2b", DIGITS);
        expect_result("b2b", 16'h0100, 1'b0, 1'b0);

        // Asynchronous reset in the second RUN cycle.
        launch(16'h00A9, 16'h0009, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_done", 32'(bus.done), 32'd0);
        expect_result("arst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_done("post_rst", DIGITS);
        expect_result("post_rst", 16'h6912, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
